// File: rtl/lc3_mem_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
// Shared types and constants for the LC-3 memory arbiter slice.
//   MEM_AW / MEM_DW : memory address / data width
//   owner_e         : arbiter FSM state (which port currently owns memory)
//   rd_tag_t        : read-return tag, one per in-flight read
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

    localparam int MEM_AW = 16;
    localparam int MEM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/lc3_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// lc3_rd_tag_pipe
// Shift register of read-return tags. A tag entering in_valid/in_port emerges
// DEPTH cycles later as rvalid0 or rvalid1. Synchronous clear drops every
// in-flight tag so no stale read ever reports valid after reset.
// Ports:
//   clk, reset        clock, synchronous active-high clear
//   in_valid, in_port tag entering the pipe this cycle
//   rvalid0, rvalid1  last stage valid, routed by its port bit
// ---------------------------------------------------------------------------
module lc3_rd_tag_pipe
    import lc3_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_port,
    output logic rvalid0,
    output logic rvalid1
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0].valid <= in_valid;
            stage[0].port  <= in_port;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign rvalid0 = stage[DEPTH-1].valid && !stage[DEPTH-1].port;
    assign rvalid1 = stage[DEPTH-1].valid &&  stage[DEPTH-1].port;

endmodule

// File: rtl/lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter
// Shares one synchronous 16-bit memory between port 0 (LC-3 core) and
// port 1 (loader / DMA). At most one request is granted per cycle; the
// accepted transaction is registered onto the memory port the next cycle
// and read data is routed back to the issuing port READ_LATENCY cycles later.
//
// Build option (macro MEM_ARB_FAIR_EN):
//   defined   : burst-limited ownership (MAX_BURST) with round-robin tie-break
//   undefined : fixed priority, port 0 always wins
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req/we/addr/wdata 0,1      requester ports, held stable until granted
//   gnt0, gnt1                 acceptance this cycle (combinational)
//   rvalid0/1, rdata0/1        read return; rdata wired to mem_rdata
//   mem_we/addr/wdata, rdata   memory port
// ---------------------------------------------------------------------------
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [MEM_AW-1:0] addr0,
    input  logic [MEM_AW-1:0] addr1,
    input  logic [MEM_DW-1:0] wdata0,
    input  logic [MEM_DW-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [MEM_DW-1:0] rdata0,
    output logic [MEM_DW-1:0] rdata1,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    input  logic [MEM_DW-1:0] mem_rdata
);

    owner_e state;
    logic   win0;
    logic   win1;
    logic   mem_we_q;
    logic   rd_q;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [3:0] cnt;
    logic       last_owner;
    logic       below_limit;

    assign below_limit = (cnt < BURST_LIMIT);
`endif

    // Arbitration decision from current owner state and live requests.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        case (state)
            OWN0: begin
                if (req0 && (below_limit || !req1)) win0 = 1'b1;
                else if (req1)                      win1 = 1'b1;
            end
            OWN1: begin
                if (req1 && (below_limit || !req0)) win1 = 1'b1;
                else if (req0)                      win0 = 1'b1;
            end
            default: begin
                // On a tie the port that did not own memory last goes first.
                if (req0 && req1) begin
                    win0 = last_owner;
                    win1 = !last_owner;
                end else begin
                    win0 = req0;
                    win1 = req1;
                end
            end
        endcase
`else
        win0 = req0;
        win1 = req1 && !req0;
`endif
    end

    assign gnt0 = win0 && !reset;
    assign gnt1 = win1 && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_we_q  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            cnt        <= '0;
            last_owner <= 1'b1;
`endif
        end else begin
            mem_we_q <= 1'b0;
            rd_q     <= (gnt0 && !we0) || (gnt1 && !we1);
            if (gnt0) begin
                mem_we_q  <= we0;
                mem_addr  <= addr0;
                mem_wdata <= wdata0;
            end else if (gnt1) begin
                mem_we_q  <= we1;
                mem_addr  <= addr1;
                mem_wdata <= wdata1;
            end
`ifdef MEM_ARB_FAIR_EN
            if (gnt0) begin
                if (state == OWN0) begin
                    if (below_limit) cnt <= cnt + 4'd1;
                end else begin
                    if (state == OWN1) last_owner <= 1'b1;
                    state <= OWN0;
                    cnt   <= 4'd1;
                end
            end else if (gnt1) begin
                if (state == OWN1) begin
                    if (below_limit) cnt <= cnt + 4'd1;
                end else begin
                    if (state == OWN0) last_owner <= 1'b0;
                    state <= OWN1;
                    cnt   <= 4'd1;
                end
            end else begin
                if (state == OWN0)      last_owner <= 1'b0;
                else if (state == OWN1) last_owner <= 1'b1;
                state <= IDLE;
            end
`else
            state <= gnt0 ? OWN0 : (gnt1 ? OWN1 : IDLE);
`endif
        end
    end

    // A registered write is dropped in any cycle reset is high.
    assign mem_we = mem_we_q && !reset;

    // Tag stage 0 is {rd_q, owner}: the owner state always names the port
    // granted last cycle, so the pipe below only needs READ_LATENCY stages.
    lc3_rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rd_q),
        .in_port  (state == OWN1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1)
    );

    assign rdata0 = mem_rdata;
    assign rdata1 = mem_rdata;

endmodule
